// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 16-bit UART transmitter between three requesters.
// The transmitter reports nothing back, so each write is followed by a fixed guard time.
module uart_tx_arbiter #(
  parameter int unsigned HOLD_CLKS = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  ack,
  output logic [2:0]  done,
  output logic        busy,
  output logic [15:0] tx_data,
  output logic        tx_wr
);

  // Handshake: req[i] is a level held until the one-cycle ack[i]; dropping it before
  // it is sampled in IDLE withdraws the request. done[i] marks the end of its guard time.
  typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_FIRE, S_HOLD} state_e;

  localparam logic [15:0] CNT_LAST = 16'(HOLD_CLKS - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  last_q, last_d;
  logic [2:0]  ack_q, ack_d;
  logic [2:0]  done_q, done_d;
  logic [15:0] tx_data_q, tx_data_d;
  logic        tx_wr_q, tx_wr_d;

  logic        win_valid;
  logic [1:0]  win;
  logic [15:0] win_data;

  // Scan order starts just after the last granted requester.
  always_comb begin
    win_valid = |req;
    unique case (last_q)
      2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
    unique case (win)
      2'd0:    win_data = data0;
      2'd1:    win_data = data1;
      default: win_data = data2;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    ack_d     = 3'b000;
    done_d    = 3'b000;
    tx_wr_d   = 1'b0;
    tx_data_d = tx_data_q;
    unique case (state_q)
      S_FLUSH: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 16'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_IDLE: begin
        if (win_valid) begin
          tx_data_d = win_data;
          ack_d     = 3'b001 << win;
          last_d    = win;
          state_d   = S_FIRE;
        end
      end
      S_FIRE: begin
        tx_wr_d = 1'b1;
        cnt_d   = 16'd0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == CNT_LAST) begin
          done_d  = 3'b001 << last_q;
          cnt_d   = 16'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FLUSH;
      cnt_q     <= 16'd0;
      last_q    <= 2'd2;
      ack_q     <= 3'b000;
      done_q    <= 3'b000;
      tx_wr_q   <= 1'b0;
      tx_data_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      tx_wr_q   <= tx_wr_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign ack     = ack_q;
  assign done    = done_q;
  assign tx_wr   = tx_wr_q;
  assign tx_data = tx_data_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed phases plus random traffic, checked every cycle
// against a timeline model (grant times, guard windows, round-robin order).
module tb_uart_tx_arbiter;

  localparam int H = 128;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [15:0] data0 = 16'h0, data1 = 16'h0, data2 = 16'h0;
  logic [2:0]  ack, done;
  logic        busy, tx_wr;
  logic [15:0] tx_data;

  uart_tx_arbiter #(.HOLD_CLKS(H)) dut (
    .clk(clk), .reset(reset), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .ack(ack), .done(done), .busy(busy), .tx_data(tx_data), .tx_wr(tx_wr)
  );

  always #5 clk = ~clk;

  // Model state: everything is expressed as absolute cycle numbers.
  int          cyc = 0;
  int          idle_from = 0;
  int          ack_at = -1, wr_at = -1, done_at = -1;
  int          gw = 0;
  int          last = 2;
  logic [15:0] data_n = 16'h0, exp_data = 16'h0;

  logic [2:0]  req_v = 3'b000;
  bit          keep_req = 1'b0;
  bit          rec_en = 1'b0;
  int          first_ack = -1;
  int          ack2_seen = 0;
  int          n_cmp = 0, n_err = 0;
  int          ack_cyc_q[$];
  logic [2:0]  exp_q[$];
  logic [2:0]  got_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs for cycle cyc, advance the model, then check cycle cyc+1.
  task automatic step(input logic rst);
    logic [2:0] r;
    logic [2:0] e_ack, e_done;
    bit found;
    int i;
    r = req_v;
    reset = rst;
    req = r;
    if (rst) begin
      idle_from = cyc + 1 + H;
      ack_at = -1; wr_at = -1; done_at = -1;
      last = 2;
      data_n = 16'h0;
    end else if (cyc >= idle_from && r != 3'b000) begin
      found = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        i = (last + k) % 3;
        if (!found && r[i]) begin
          found = 1'b1;
          gw = i;
        end
      end
      last = gw;
      data_n = (gw == 0) ? data0 : ((gw == 1) ? data1 : data2);
      ack_at = cyc + 1;
      wr_at = cyc + 2;
      done_at = cyc + 2 + H;
      idle_from = cyc + 2 + H;
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_data = data_n;
    e_ack = (cyc == ack_at) ? (3'b001 << gw) : 3'b000;
    e_done = (cyc == done_at) ? (3'b001 << gw) : 3'b000;
    chk("ack", 32'(ack), 32'(e_ack));
    chk("done", 32'(done), 32'(e_done));
    chk("tx_wr", 32'(tx_wr), 32'(cyc == wr_at));
    chk("busy", 32'(busy), 32'(cyc < idle_from));
    chk("tx_data", 32'(tx_data), 32'(exp_data));
    if (ack !== 3'b000 && first_ack < 0) first_ack = cyc;
    if (ack[2] === 1'b1) ack2_seen++;
    if (rec_en && ack !== 3'b000) begin
      ack_cyc_q.push_back(cyc);
      got_q.push_back(ack);
    end
    if (!keep_req) req_v = req_v & ~e_ack;
  endtask

  task automatic do_reset(input int n);
    req_v = 3'b000;
    repeat (n) step(1'b1);
  endtask

  task automatic wait_idle;
    int guard;
    guard = 0;
    while (cyc < idle_from && guard < 1000) begin
      step(1'b0);
      guard++;
    end
    chk("idle_timeout", 32'(guard < 1000), 32'd1);
  endtask

  int rel;
  int exp_first;
  int guard;

  initial begin
    // Let the DUT see reset before anything is compared.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Phase 1: flush after reset with req[0] held throughout.
    keep_req = 1'b1;
    req_v = 3'b001;
    repeat (3) step(1'b1);
    req_v = 3'b001;
    rel = cyc;
    first_ack = -1;
    repeat (H + 2) step(1'b0);
    chk("flush_first_ack", 32'(first_ack), 32'(rel + H + 1));
    keep_req = 1'b0;
    req_v = 3'b000;
    wait_idle();

    // Phase 2: single request from requester 1.
    data1 = 16'hA55A;
    req_v = 3'b010;
    repeat (H + 5) step(1'b0);

    // Phase 3: payload change during HOLD must not reach tx_data.
    data0 = 16'h1234;
    req_v = 3'b001;
    repeat (5) step(1'b0);
    data0 = 16'hFFFF;
    repeat (H + 2) step(1'b0);
    wait_idle();

    // Phase 4: all three held continuously from reset, grants 0,1,2,0.
    do_reset(3);
    keep_req = 1'b1;
    req_v = 3'b111;
    rec_en = 1'b1;
    guard = 0;
    while (ack_cyc_q.size() < 4 && guard < 2000) begin
      step(1'b0);
      guard++;
    end
    rec_en = 1'b0;
    keep_req = 1'b0;
    req_v = 3'b000;
    exp_q = '{3'b001, 3'b010, 3'b100, 3'b001};
    chk("rr_count", 32'(ack_cyc_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < ack_cyc_q.size(); k++) begin
      chk("rr_order", 32'(got_q[k]), 32'(exp_q[k]));
      if (k > 0) chk("rr_spacing", 32'(ack_cyc_q[k] - ack_cyc_q[k-1]), 32'(H + 2));
    end
    wait_idle();

    // Phase 5: reset at cnt = 50 in HOLD aborts the grant and forces a full flush.
    req_v = 3'b001;
    guard = 0;
    while (cyc != wr_at && guard < 500) begin
      step(1'b0);
      guard++;
    end
    chk("hold_reached", 32'(cyc), 32'(wr_at));
    repeat (50) step(1'b0);
    step(1'b1);
    req_v = 3'b100;
    rel = cyc;
    first_ack = -1;
    repeat (H + 4) step(1'b0);
    chk("abort_first_ack", 32'(first_ack), 32'(rel + H + 1));
    wait_idle();

    // Phase 6: req[2] pulsed only during HOLD is never acked; held into IDLE it is.
    data0 = 16'h0F0F;
    req_v = 3'b001;
    repeat (10) step(1'b0);
    ack2_seen = 0;
    req_v = 3'b100;
    step(1'b0);
    req_v = 3'b000;
    wait_idle();
    repeat (4) step(1'b0);
    chk("pulse_no_ack", 32'(ack2_seen), 32'd0);
    req_v = 3'b001;
    repeat (10) step(1'b0);
    data2 = 16'hBEEF;
    req_v = 3'b100;
    exp_first = idle_from + 1;
    first_ack = -1;
    wait_idle();
    repeat (3) step(1'b0);
    chk("held_ack_time", 32'(first_ack), 32'(exp_first));

    // Phase 7: random requests, withdrawals, payload churn and rare resets.
    repeat (3000) begin
      for (int k = 0; k < 3; k++) begin
        if (!req_v[k] && $urandom_range(0, 29) == 0) begin
          req_v[k] = 1'b1;
          if (k == 0) data0 = 16'($urandom);
          else if (k == 1) data1 = 16'($urandom);
          else data2 = 16'($urandom);
        end else if (req_v[k] && $urandom_range(0, 199) == 0) begin
          req_v[k] = 1'b0;
        end
      end
      if ($urandom_range(0, 9) == 0) data1 = 16'($urandom);
      step($urandom_range(0, 799) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single 16-bit UART transmitter between three requesters (e.g. board-state update, score/status, debug message) using round-robin arbitration.
- The transmitter has no busy or done output, so this block generates its one-cycle write strobe and then blocks for a fixed guard time covering a full two-byte frame.
- It sits between the game logic and the transmitter: its tx_data and tx_wr drive the transmitter's 16-bit data input and its write-strobe input directly.

Parameters:
- HOLD_CLKS, 128: clocks to block after each tx_wr pulse. Legal range 2..65535. Must be >= 24*CLKS_PER_BIT of the transmitter (120 at the transmitter's CLKS_PER_BIT = 5).

Ports:
- clk  input  1: system clock; all logic on its rising edge.
- reset  input  1: synchronous, active-high reset.
- req  input  3: req[i] level request from requester i. Held high until ack[i].
- data0  input  16: payload of requester 0.
- data1  input  16: payload of requester 1.
- data2  input  16: payload of requester 2.
- ack  output  3: one-hot, 1-cycle pulse. Payload of requester i has been captured.
- done  output  3: one-hot, 1-cycle pulse. Guard time for requester i's frame has elapsed.
- busy  output  1: high in every state except IDLE.
- tx_data  output  16: registered payload to the transmitter. Stable from the ack cycle to the end of HOLD.
- tx_wr  output  1: 1-cycle write strobe to the transmitter.

Behaviour:
- States: FLUSH, IDLE, FIRE, HOLD. Counter cnt is 16 bits. Pointer last is 2 bits and holds the index of the last granted requester.
- Reset (sync, any state, including mid-HOLD):
  - state <= FLUSH, cnt <= 0, last <= 2.
  - ack = 0, done = 0, tx_wr = 0, tx_data = 0, busy = 1.
  - Outstanding grant abandoned; no done pulse is issued for it.
- FLUSH: the transmitter has no reset and may still be mid-frame, so the block waits.
  - cnt increments each cycle.
  - When cnt == HOLD_CLKS-1: cnt <= 0, state <= IDLE.
  - Requests are ignored in FLUSH. First possible ack is HOLD_CLKS+1 cycles after reset deasserts.
- IDLE: busy = 0. req is sampled only in this state.
  - If req == 0: remain in IDLE.
  - Otherwise the winner w is the first i with req[i] = 1, scanning in order last+1, last+2, last+3 (mod 3).
  - On the edge: tx_data <= data_w, ack[w] <= 1, last <= w, state <= FIRE.
- FIRE: lasts one cycle. ack[w] is high this cycle.
  - On the edge: tx_wr <= 1, cnt <= 0, state <= HOLD.
- HOLD: tx_wr is high only in the first HOLD cycle. cnt increments each cycle.
  - When cnt == HOLD_CLKS-1: done[w] <= 1, state <= IDLE.
- Timing, with req sampled in IDLE at cycle t:
  - ack at t+1, tx_wr at t+2, done at t+2+HOLD_CLKS.
  - The next ack is no earlier than t+3+HOLD_CLKS.
  - The done cycle is an IDLE cycle and may arbitrate a new request.
- Requests and data capture:
  - req rising during FIRE or HOLD is pending and is served from the next IDLE.
  - req dropped before being sampled is a withdrawal; nothing is sent.
  - data_i is sampled only on the IDLE→FIRE edge. Later changes do not affect tx_data.
- Simultaneous requests: resolved by round-robin only. A requester re-asserting immediately after its done cannot win over another pending requester.
- Outputs: ack, done and tx_wr are never high for more than one consecutive cycle. At most one bit of ack and of done is high.

Test Plan:
- Reset held 3 cycles, then released; req = 3'b001 throughout → busy = 1 and ack = 0 for 128 cycles; ack = 3'b001 at cycle 129 after release; tx_wr pulse next cycle.
- After flush, data1 = 16'hA55A, req = 3'b010 → ack[1] at t+1; tx_data = 16'hA55A from t+1; tx_wr = 1 only at t+2; done = 3'b010 at t+130; busy low from t+130.
- req = 3'b111 held continuously, last = 2 after reset → grants in order 0, 1, 2, 0, each ack spaced exactly HOLD_CLKS+2 cycles apart.
- data0 = 16'h1234 captured, then data0 changed to 16'hFFFF during HOLD → tx_data stays 16'h1234 until IDLE.
- Reset asserted at cnt = 50 in HOLD → next cycle tx_wr = 0, done = 0, state FLUSH; no done for the aborted grant; full 128-cycle flush precedes the next ack.
- req[2] pulsed high for 1 cycle during HOLD only → never acked; req[2] held from HOLD into IDLE → acked at first IDLE + 1.
